// File: rtl/synth_pkg.sv
// Shared types for the voice engine.
//   reg_addr_e : register-port address map (one word per voice per address)
//   phase_t    : phase accumulator / phase step word
//   level_t    : envelope level and attack/release rate word
//   sample_t   : signed audio sample
//   tri_wave() : triangle waveform from a phase word
package synth_pkg;

  typedef enum logic [1:0] {
    PHASE_STEP   = 2'd0,
    ATTACK_RATE  = 2'd1,
    RELEASE_RATE = 2'd2,
    GATE         = 2'd3
  } reg_addr_e;

  typedef logic [15:0]        phase_t;
  typedef logic [15:0]        level_t;
  typedef logic signed [15:0] sample_t;

  // Rising half for p[15]=0, falling half for p[15]=1. Both branches are
  // evaluated mod 2^16, which lands exactly in the signed 16-bit range.
  function automatic sample_t tri_wave(input phase_t p);
    logic [15:0] u;
    u = {p[14:0], 1'b0};
    if (p[15]) begin
      tri_wave = sample_t'(16'h7FFF - u);
    end else begin
      tri_wave = sample_t'({~u[15], u[14:0]});
    end
  endfunction

endpackage

// File: rtl/voice_waveform.sv
// Triangle generator and envelope scaler for one voice slot.
//   i_Clock, i_Reset_n : clock, asynchronous active-low reset
//   i_Phase            : updated phase of the voice being processed
//   i_Level            : updated envelope level of that voice
//   o_Scaled           : (triangle * level) >>> 16, registered (1-cycle latency)
module voice_waveform
  import synth_pkg::*;
(
  input  logic        i_Clock,
  input  logic        i_Reset_n,
  input  logic [15:0] i_Phase,
  input  logic [15:0] i_Level,
  output logic [15:0] o_Scaled
);

  sample_t            wave;
  logic signed [16:0] wave_ext;
  logic signed [16:0] level_ext;
  logic signed [33:0] product;
  logic               unused_product_bits;

  always_comb begin
    wave      = tri_wave(i_Phase);
    wave_ext  = {wave[15], wave};
    level_ext = {1'b0, i_Level};
    product   = wave_ext * level_ext;
  end

  // |product| < 2^31, so bits [31:16] are the arithmetic shift by 16.
  assign unused_product_bits = ^{product[33:32], product[15:0]};

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      o_Scaled <= '0;
    end else begin
      o_Scaled <= product[31:16];
    end
  end

endmodule

// File: rtl/synth_voice_engine.sv
// Time-multiplexed multi-voice synth: per frame, steps every voice's phase
// accumulator and linear envelope, scales a triangle by the envelope and
// outputs the average of all voices.
//   i_Clock, i_Reset_n : clock, asynchronous active-low reset
//   i_WriteEnable      : register write strobe
//   i_WriteVoice       : target voice of the write
//   i_WriteAddr        : 0 phase step, 1 attack, 2 release, 3 gate (data bit 0)
//   i_WriteData        : write data
//   o_VoiceActive      : bit v set while voice v has a non-zero level
//   o_SampleReady      : one-cycle strobe when o_Sample updates
//   o_Sample           : signed averaged output sample
module synth_voice_engine
  import synth_pkg::*;
#(
  parameter int unsigned NUM_VOICES    = 8,
  parameter int unsigned SAMPLE_PERIOD = 256,
  parameter int unsigned PHASE_WIDTH   = 16,
  parameter int unsigned SAMPLE_WIDTH  = 16
) (
  input  logic                          i_Clock,
  input  logic                          i_Reset_n,
  input  logic                          i_WriteEnable,
  input  logic [$clog2(NUM_VOICES)-1:0] i_WriteVoice,
  input  logic [1:0]                    i_WriteAddr,
  input  logic [15:0]                   i_WriteData,
  output logic [NUM_VOICES-1:0]         o_VoiceActive,
  output logic                          o_SampleReady,
  output logic [SAMPLE_WIDTH-1:0]       o_Sample
);

  localparam int unsigned VW = $clog2(NUM_VOICES);
  localparam int unsigned CW = $clog2(SAMPLE_PERIOD);
  localparam int unsigned AW = SAMPLE_WIDTH + VW;

  localparam logic [CW-1:0] LAST_CNT  = CW'(SAMPLE_PERIOD - 1);
  localparam logic [CW-1:0] VOICE_CNT = CW'(NUM_VOICES);
  localparam logic [CW-1:0] OUT_CNT   = CW'(NUM_VOICES + 1);

  logic [CW-1:0]          count_q;
  logic [PHASE_WIDTH-1:0] step_q    [NUM_VOICES];
  logic [PHASE_WIDTH-1:0] phase_q   [NUM_VOICES];
  level_t                 attack_q  [NUM_VOICES];
  level_t                 release_q [NUM_VOICES];
  level_t                 level_q   [NUM_VOICES];
  logic [NUM_VOICES-1:0]  gate_q;
  logic [NUM_VOICES-1:0]  retrig_q;
  logic signed [AW-1:0]   acc_q;

  logic [VW-1:0]          vidx;
  logic                   proc_en;
  logic                   acc_en;
  logic [PHASE_WIDTH-1:0] phase_nxt;
  level_t                 level_nxt;
  logic [16:0]            attack_sum;
  logic [15:0]            scaled;
  reg_addr_e              wr_addr;

  always_comb begin
    vidx       = count_q[VW-1:0];
    proc_en    = (count_q < VOICE_CNT);
    acc_en     = (count_q != '0) && (count_q <= VOICE_CNT);
    wr_addr    = reg_addr_e'(i_WriteAddr);
    phase_nxt  = retrig_q[vidx] ? step_q[vidx] : phase_q[vidx] + step_q[vidx];
    attack_sum = {1'b0, level_q[vidx]} + {1'b0, attack_q[vidx]};
    level_nxt  = '0;
    if (gate_q[vidx]) begin
      level_nxt = attack_sum[16] ? '1 : attack_sum[15:0];
    end else if (level_q[vidx] > release_q[vidx]) begin
      level_nxt = level_q[vidx] - release_q[vidx];
    end
  end

  voice_waveform u_wave (
    .i_Clock   (i_Clock),
    .i_Reset_n (i_Reset_n),
    .i_Phase   (phase_nxt),
    .i_Level   (level_nxt),
    .o_Scaled  (scaled)
  );

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      count_q       <= '0;
      gate_q        <= '0;
      retrig_q      <= '0;
      acc_q         <= '0;
      o_VoiceActive <= '0;
      o_SampleReady <= 1'b0;
      o_Sample      <= '0;
      for (int unsigned v = 0; v < NUM_VOICES; v++) begin
        step_q[v]    <= '0;
        phase_q[v]   <= '0;
        attack_q[v]  <= '0;
        release_q[v] <= '0;
        level_q[v]   <= '0;
      end
    end else begin
      count_q <= (count_q == LAST_CNT) ? '0 : count_q + 1'b1;

      if (proc_en) begin
        phase_q[vidx]       <= phase_nxt;
        level_q[vidx]       <= level_nxt;
        retrig_q[vidx]      <= 1'b0;
        o_VoiceActive[vidx] <= (level_nxt != '0);
      end

      // Register writes come after the processing update so a gate write in
      // the voice's own slot keeps its retrigger flag past the clear above.
      if (i_WriteEnable) begin
        case (wr_addr)
          PHASE_STEP:   step_q[i_WriteVoice]    <= i_WriteData;
          ATTACK_RATE:  attack_q[i_WriteVoice]  <= i_WriteData;
          RELEASE_RATE: release_q[i_WriteVoice] <= i_WriteData;
          GATE: begin
            gate_q[i_WriteVoice] <= i_WriteData[0];
            if (i_WriteData[0] && !gate_q[i_WriteVoice]) begin
              retrig_q[i_WriteVoice] <= 1'b1;
            end
          end
        endcase
      end

      // The scaled sample of voice v arrives one clock later, at count v+1.
      if (count_q == '0) begin
        acc_q <= '0;
      end else if (acc_en) begin
        acc_q <= acc_q + {{(AW-16){scaled[15]}}, scaled};
      end

      o_SampleReady <= (count_q == OUT_CNT);
      if (count_q == OUT_CNT) begin
        o_Sample <= SAMPLE_WIDTH'(acc_q >>> VW);
      end
    end
  end

endmodule

// File: tb/tb_synth_voice_engine.sv
// Bench for synth_voice_engine: a table of register writes and per-frame
// expected outputs, plus hand-written sequences for the same-slot gate
// write and the mid-frame reset. Expected frames go into a scoreboard queue
// that a monitor pops on every o_SampleReady.
module tb_synth_voice_engine;

  localparam int unsigned NV  = 8;
  localparam int unsigned SP  = 256;
  localparam int unsigned GAP = NV + 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        we = 1'b0;
  logic [2:0]  wv = '0;
  logic [1:0]  wa = '0;
  logic [15:0] wd = '0;
  logic [7:0]  active;
  logic        rdy;
  logic [15:0] sample;

  synth_voice_engine #(
    .NUM_VOICES    (NV),
    .SAMPLE_PERIOD (SP),
    .PHASE_WIDTH   (16),
    .SAMPLE_WIDTH  (16)
  ) dut (
    .i_Clock       (clk),
    .i_Reset_n     (rst_n),
    .i_WriteEnable (we),
    .i_WriteVoice  (wv),
    .i_WriteAddr   (wa),
    .i_WriteData   (wd),
    .o_VoiceActive (active),
    .o_SampleReady (rdy),
    .o_Sample      (sample)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_frame;
    int unsigned voice;
    logic [1:0]  addr;
    logic [15:0] data;
    logic [15:0] exp_s;
    logic [7:0]  exp_a;
  } vec_t;

  typedef struct {
    logic [15:0] s;
    logic [7:0]  a;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;

  // Frame position as the DUT should see it, and clock edges since reset.
  logic [7:0] cnt;
  int         edges;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      edges <= 0;
    end else begin
      cnt   <= (cnt == 8'(SP - 1)) ? 8'd0 : cnt + 8'd1;
      edges <= edges + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic vec_t mk_wr(input int unsigned v, input logic [1:0] a, input logic [15:0] d);
    vec_t r;
    r.is_frame = 1'b0; r.voice = v; r.addr = a; r.data = d; r.exp_s = '0; r.exp_a = '0;
    return r;
  endfunction

  function automatic vec_t mk_fr(input logic [15:0] s, input logic [7:0] a);
    vec_t r;
    r.is_frame = 1'b1; r.voice = 0; r.addr = '0; r.data = '0; r.exp_s = s; r.exp_a = a;
    return r;
  endfunction

  task automatic wait_cnt(input int unsigned v);
    int n = 0;
    while (cnt != 8'(v) && n < 600) begin
      @(negedge clk);
      n++;
    end
    if (cnt != 8'(v)) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_cnt: frame position %0d, required %0d", cnt, v);
    end
  endtask

  task automatic wr(input int unsigned v, input logic [1:0] a, input logic [15:0] d);
    we = 1'b1; wv = 3'(v); wa = a; wd = d;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic push(input logic [15:0] s, input logic [7:0] a);
    exp_t e;
    e.s = s;
    e.a = a;
    sb.push_back(e);
  endtask

  task automatic apply(input vec_t v);
    if (v.is_frame) begin
      push(v.exp_s, v.exp_a);
      wait_cnt(0);
      wait_cnt(GAP);
    end else begin
      if (cnt < 8'(GAP) || cnt > 8'd240) wait_cnt(GAP);
      wr(v.voice, v.addr, v.data);
    end
  endtask

  // Output monitor: pops the scoreboard and checks strobe width and period.
  int   last_edge = 0;
  bit   first_rdy = 1'b1;
  logic prev_rdy = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      first_rdy = 1'b1;
      last_edge = 0;
      prev_rdy  = 1'b0;
    end else begin
      if (rdy) begin
        exp_t e;
        check("ready_width", 32'(prev_rdy), 32'd0);
        check("ready_period", 32'(edges - last_edge), first_rdy ? NV + 2 : SP);
        first_rdy = 1'b0;
        last_edge = edges;
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_ready: got sample 0x%h, required no output", sample);
        end else begin
          e = sb.pop_front();
          check("sample", 32'(sample), 32'(e.s));
          check("active", 32'(active), 32'(e.a));
        end
      end
      prev_rdy = rdy;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // First frame after reset: silence.
    tbl.push_back(mk_fr(16'h0000, 8'h00));
    // Single voice: level 0xFFFF, phase 0x0100 then 0x0200.
    tbl.push_back(mk_wr(0, 2'd0, 16'h0100));
    tbl.push_back(mk_wr(0, 2'd1, 16'hFFFF));
    tbl.push_back(mk_wr(0, 2'd3, 16'h0001));
    tbl.push_back(mk_fr(16'hF040, 8'h01));   // -4032
    tbl.push_back(mk_fr(16'hF080, 8'h01));   // -3968
    // Release floor: levels 0xBFFF, 0x7FFF, 0x3FFF, 0, 0.
    tbl.push_back(mk_wr(0, 2'd2, 16'h4000));
    tbl.push_back(mk_wr(0, 2'd3, 16'h0000));
    tbl.push_back(mk_fr(16'hF490, 8'h01));   // -2928
    tbl.push_back(mk_fr(16'hF880, 8'h01));   // -1920
    tbl.push_back(mk_fr(16'hFC50, 8'h01));   // -944
    tbl.push_back(mk_fr(16'h0000, 8'h00));
    tbl.push_back(mk_fr(16'h0000, 8'h00));
    // Full-scale mix on all voices.
    for (int v = 0; v < NV; v++) begin
      tbl.push_back(mk_wr(v, 2'd0, 16'h8000));
      tbl.push_back(mk_wr(v, 2'd1, 16'hFFFF));
      tbl.push_back(mk_wr(v, 2'd3, 16'h0001));
    end
    tbl.push_back(mk_fr(16'h7FFE, 8'hFF));   // 32766
    tbl.push_back(mk_fr(16'h8000, 8'hFF));   // -32768
    tbl.push_back(mk_fr(16'h7FFE, 8'hFF));
    // Phase wrap: retrigger every voice with step 0xFFFF.
    for (int v = 0; v < NV; v++) begin
      tbl.push_back(mk_wr(v, 2'd0, 16'hFFFF));
      tbl.push_back(mk_wr(v, 2'd3, 16'h0000));
      tbl.push_back(mk_wr(v, 2'd3, 16'h0001));
    end
    tbl.push_back(mk_fr(16'h8001, 8'hFF));   // phase 0xFFFF: -32767
    tbl.push_back(mk_fr(16'h8003, 8'hFF));   // phase 0xFFFE: -32765
    tbl.push_back(mk_fr(16'h8005, 8'hFF));   // phase 0xFFFD: -32763
    // Only voice 3 left sounding, retriggered with step 0x1000.
    for (int v = 0; v < NV; v++) begin
      if (v != 3) begin
        tbl.push_back(mk_wr(v, 2'd2, 16'hFFFF));
        tbl.push_back(mk_wr(v, 2'd3, 16'h0000));
      end
    end
    tbl.push_back(mk_wr(3, 2'd0, 16'h1000));
    tbl.push_back(mk_wr(3, 2'd3, 16'h0000));
    tbl.push_back(mk_wr(3, 2'd3, 16'h0001));
    tbl.push_back(mk_fr(16'hF400, 8'h08));   // phase 0x1000: -3072

    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_sample", 32'(sample), 32'd0);
    check("reset_ready", 32'(rdy), 32'd0);
    check("reset_active", 32'(active), 32'd0);
    rst_n = 1'b1;

    foreach (tbl[i]) apply(tbl[i]);

    // Gate 1 written in voice 3's own slot: this frame advances normally
    // (phase 0x2000, level held by zero release), the next restarts at the step.
    apply(mk_wr(3, 2'd2, 16'h0000));
    apply(mk_wr(3, 2'd3, 16'h0000));
    push(16'hF800, 8'h08);                   // -2048
    wait_cnt(0);
    wait_cnt(3);
    wr(3, 2'd3, 16'h0001);
    wait_cnt(GAP);
    apply(mk_fr(16'hF400, 8'h08));           // phase 0x1000 again
    apply(mk_fr(16'hF800, 8'h08));           // phase 0x2000

    // Mid-frame reset with voice 3 active and a non-zero held sample.
    wait_cnt(5);
    check("pre_reset_active", 32'(active), 32'h08);
    check("pre_reset_sample", 32'(sample), 32'hF800);
    rst_n = 1'b0;
    #1;
    check("midframe_reset_sample", 32'(sample), 32'd0);
    check("midframe_reset_ready", 32'(rdy), 32'd0);
    check("midframe_reset_active", 32'(active), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    apply(mk_fr(16'h0000, 8'h00));
    apply(mk_wr(0, 2'd0, 16'h0100));
    apply(mk_wr(0, 2'd1, 16'hFFFF));
    apply(mk_wr(0, 2'd3, 16'h0001));
    apply(mk_fr(16'hF040, 8'h01));

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/synth_voice_engine.md
Name: synth_voice_engine

Overview:
- Parameterised, time-multiplexed successor to the single-operator synth top.
- Holds per-voice phase step, attack/release rates and gate in internal registers, written through a simple register port.
- Each output frame, steps NUM_VOICES phase accumulators and linear attack/release envelopes, generates a triangle wave per voice, scales it by the envelope, and averages all voices into one signed output sample with a one-cycle ready strobe.

Parameters:
- NUM_VOICES, 8, voice count; power of two, 2..64.
- SAMPLE_PERIOD, 256, clocks per output frame; must be ≥ NUM_VOICES+3.
- PHASE_WIDTH, 16, phase accumulator and step width; fixed 16 in this generation.
- SAMPLE_WIDTH, 16, signed output width.

Ports:
- i_Clock  in  1  system clock.
- i_Reset_n  in  1  asynchronous, active-low reset.
- i_WriteEnable  in  1  register write strobe, one write per cycle.
- i_WriteVoice  in  $clog2(NUM_VOICES)  target voice.
- i_WriteAddr  in  2  0 = PHASE_STEP, 1 = ATTACK_RATE, 2 = RELEASE_RATE, 3 = GATE (bit 0 of data).
- i_WriteData  in  16  write data, unsigned.
- o_VoiceActive  out  NUM_VOICES  bit v = (level[v] != 0).
- o_SampleReady  out  1  one-cycle pulse when o_Sample updates.
- o_Sample  out  SAMPLE_WIDTH  signed mixed sample.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. All voice registers, phases, levels, retrigger flags, frame counter, accumulator, o_Sample, o_SampleReady and o_VoiceActive go to 0. A mid-frame reset aborts the frame with no partial output.
- Frame counter: runs 0..SAMPLE_PERIOD-1 and wraps. The first frame starts on the first clock after reset deasserts.
- Cycle count = v (v < NUM_VOICES) processes voice v using register values as they stand at the start of that cycle:
  - phase' = retrig[v] ? step[v] : phase[v] + step[v], mod 2^16. The retrigger flag is then cleared.
  - gate = 1: level' = min(level + attack, 0xFFFF).
  - gate = 0: level' = max(level − release, 0).
  - Both results are written back.
- Waveform, from the updated phase p, with u = {p[14:0],1'b0}:
  - p[15] = 0: w = u − 32768.
  - p[15] = 1: w = 32767 − u.
  - w is signed 16-bit.
- Scale: s = (w × level') >>> 16, using a signed 17×17 product with arithmetic shift, so s fits 16 bits. Registered one stage after voice processing.
- Accumulator: signed, SAMPLE_WIDTH + $clog2(NUM_VOICES) bits.
  - Cleared to 0 at count 0.
  - Adds s for voice v at count v+1.
- Output: at count NUM_VOICES+1, o_Sample ← acc >>> $clog2(NUM_VOICES), i.e. the average. No saturation is needed. o_SampleReady is 1 for that cycle only; o_Sample holds until the next frame.
- Register writes:
  - Take effect at the clock edge. A write in the same cycle the target voice is processed does not affect that processing.
  - A GATE write of 1 while gate is 0 sets retrig[v]. A same-cycle write survives that cycle's flag clear.
  - A GATE write of 1 while already 1 is a no-op.
  - Phase and level are not directly writable.
- o_VoiceActive: registered, updated as each voice is written back.

Decomposition:
- Package synth_pkg holds:
  - the reg_addr_e enum (PHASE_STEP, ATTACK_RATE, RELEASE_RATE, GATE);
  - the phase_t and level_t (16-bit unsigned) typedefs;
  - sample_t (signed 16-bit).
- Sub-module voice_waveform: phase and level in, registered scaled sample s out. Contains the triangle generation and multiply; one-cycle latency.
- Voice state is held in register arrays indexed by the frame counter.

Test Plan:
- Reset: assert i_Reset_n = 0 mid-frame with voices active → all outputs 0 immediately. After release, the first o_SampleReady arrives at clock NUM_VOICES+1 with o_Sample = 0.
- Single voice: voice 0 with step 0x0100, attack 0xFFFF, gate 1 → first frame gives level 0xFFFF, phase 0x0100, o_Sample = −4032, o_VoiceActive = 0x01.
- Full-scale mix: all 8 voices with step 0x8000, attack 0xFFFF, gate 1 → first frame o_Sample = 32766; second frame (phase wraps to 0) o_Sample = −32768 >>> 0 path, w = −32768, s = −32768, o_Sample = −32768.
- Release floor: after the single-voice setup, set release 0x4000 and gate 0 → level goes 0xBFFF, 0x7FFF, 0x3FFF, 0 over four frames. Then o_Sample = 0, o_VoiceActive = 0, and level stays 0 (no underflow).
- Retrigger collision: write gate 0 then gate 1 to voice 3 in the same cycle voice 3 is processed → that frame uses the old phase; the next frame's phase equals the step exactly.
- Phase wrap and timing: step 0xFFFF → phase sequence 0xFFFF, 0xFFFE, 0xFFFD. Check o_SampleReady is exactly one cycle wide every SAMPLE_PERIOD clocks.
